// File: rtl/seg7_scanner.sv
// Multiplexed seven-segment scanner: one digit is lit per scan step. A frame's value,
// decimal points and blanking mode are latched in shadow registers when the scan wraps.
module seg7_scanner #(
  parameter int NUM_DIGITS       = 4,     // legal range 2..8
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    d_clock,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};

  // sync_q[0] and sync_q[1] resynchronise d_clock; sync_q[2] is the history flop.
  logic [2:0]              sync_q;
  logic                    step;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    blank_lz_q, blank_lz_d;
  logic                    frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              segment_q, segment_d;
  logic                    dp_out_q, dp_out_d;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_zero_above;
  logic                    lit;

  assign step = sync_q[1] & ~sync_q[2];

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'h3F;
      4'h1:    hex_decode = 7'h06;
      4'h2:    hex_decode = 7'h5B;
      4'h3:    hex_decode = 7'h4F;
      4'h4:    hex_decode = 7'h66;
      4'h5:    hex_decode = 7'h6D;
      4'h6:    hex_decode = 7'h7D;
      4'h7:    hex_decode = 7'h07;
      4'h8:    hex_decode = 7'h7F;
      4'h9:    hex_decode = 7'h6F;
      4'hA:    hex_decode = 7'h77;
      4'hB:    hex_decode = 7'h7C;
      4'hC:    hex_decode = 7'h39;
      4'hD:    hex_decode = 7'h5E;
      4'hE:    hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // Scan index and shadow capture; the shadows only change when the scan wraps.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    index_d    = index_q;
    value_d    = value_q;
    dp_d       = dp_q;
    blank_lz_d = blank_lz_q;
    frame_d    = 1'b0;
    if (step && enable) begin
      if (index_q == LAST_IDX) begin
        index_d    = '0;
        value_d    = value;
        dp_d       = dp;
        blank_lz_d = blank_lz;
        frame_d    = 1'b1;
      end else begin
        index_d = index_q + 1'b1;
      end
    end
  end

  // Drive for the selected digit, taken purely from the shadow registers.
  always_comb begin
    cur_nib        = '0;
    cur_dp         = 1'b0;
    cur_zero_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        cur_nib        = value_q[4*i +: 4];
        cur_dp         = dp_q[i];
        cur_zero_above = ((value_q >> (4*i)) == '0);
      end
    end
    lit       = enable & ~(blank_lz_q & (index_q != '0) & cur_zero_above);
    anode_d   = lit ? ((NUM_DIGITS'(1) << index_q) ^ ANODE_OFF) : ANODE_OFF;
    segment_d = (lit ? hex_decode(cur_nib) : 7'h00) ^ SEG_OFF;
    dp_out_d  = (lit & cur_dp) ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync_q     <= '0;
      index_q    <= LAST_IDX;
      value_q    <= '0;
      dp_q       <= '0;
      blank_lz_q <= 1'b0;
      frame_q    <= 1'b0;
      anode_q    <= ANODE_OFF;
      segment_q  <= SEG_OFF;
      dp_out_q   <= SEG_ACTIVE_LOW;
    end else begin
      sync_q     <= {sync_q[1:0], d_clock};
      index_q    <= index_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      blank_lz_q <= blank_lz_d;
      frame_q    <= frame_d;
      anode_q    <= anode_d;
      segment_q  <= segment_d;
      dp_out_q   <= dp_out_d;
    end
  end

  assign anode       = anode_q;
  assign segment     = segment_q;
  assign dp_out      = dp_out_q;
  assign frame_start = frame_q;

endmodule
